// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states,
// and the legality check applied to every accepted request.
package lsu_pkg;

    localparam int ADDR_W      = 7;
    localparam int WORD_ADDR_W = 5;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } state_e;

    // A request is bad when its size is illegal or its address is not
    // naturally aligned to that size.
    function automatic logic is_bad_req(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store unit: picks the addressed byte/half out of
// a memory word with sign or zero extension, and merges sub-word store data
// into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rd_data,
    input  logic [1:0]        addr_lo,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged_data
);

    logic [4:0]  byte_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane selection: byte lane addr_lo, half lane addr_lo[1]
    always_comb begin
        byte_off = {addr_lo, 3'b000};
        byte_sel = rd_data[byte_off +: 8];
        half_sel = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    end

    // Extend the selected lane to a full word for load results
    always_comb begin
        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:   load_data = rd_data;
        endcase
    end

    // Replace the target lane of the read word with the store data
    always_comb begin
        // NOTE: assigning a full default before the case keeps every path
        // driven, so no latch is inferred for the untouched lanes.
        merged_data = rd_data;
        case (size)
            SIZE_BYTE: merged_data[byte_off +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (addr_lo[1]) merged_data[31:16] = wdata[15:0];
                else            merged_data[15:0]  = wdata[15:0];
            end
            default:   merged_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a 32-word asynchronous-read
// memory. Loads and word stores take one memory cycle; byte/half stores do a
// read-modify-write over two cycles. Bad requests answer at once with an error.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    output logic                   mem_wr_en,
    input  logic [DATA_W-1:0]      mem_rd_data
);

    state_e              state_q,    state_d;
    logic                is_store_q, is_store_d;
    size_e               size_q,     size_d;
    logic                unsigned_q, unsigned_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [DATA_W-1:0]   merged_q,   merged_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic                err_q,      err_d;

    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   merged_data;

    lsu_align u_align (
        .rd_data     (mem_rd_data),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    // NOTE: reset forces IDLE asynchronously, so ready is also gated by rst to
    // stay low for the whole time reset is held.
    assign req_ready  = (state_q == ST_IDLE) & rst;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = addr_q[ADDR_W-1:2];

    // Next-state, request capture and memory strobe generation
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merged_d    = merged_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    is_store_d = req_is_store;
                    size_d     = size_e'(req_size);
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    err_d      = is_bad_req(size_e'(req_size), req_addr[1:0]);
                    state_d    = err_d ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!is_store_q) begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end else if (size_q == SIZE_WORD) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = wdata_q;
                    state_d     = ST_RESP;
                end else begin
                    merged_d = merged_data;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = merged_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merged_q   <= merged_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule
